cosine2x_lut_sequencer: RTL and testbench

//  Front-end controller for the cosine2x lookup table. Accepts an integer angle in degrees over a

---
 rtl/cosine2x_lut_sequencer_pkg.sv | 49 ++++
 rtl/cosine2x_lut_sequencer_if.sv | 29 ++
 rtl/cosine2x_lut_sequencer_angle_mod360_reducer.sv | 58 +++++
 rtl/cosine2x_lut_sequencer.sv | 112 +++++++++++
 tb/tb_cosine2x_lut_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cosine2x_lut_sequencer_pkg.sv
// Shared constants, FSM encoding and quadrant mapping for the cosine2x LUT sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
package cosine2x_lut_sequencer_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int RESULT_WIDTH = 2 * DATA_WIDTH;
    localparam int REM_WIDTH    = 9;

    localparam logic [REM_WIDTH-1:0] DEG_90  = 9'd90;
    localparam logic [REM_WIDTH-1:0] DEG_180 = 9'd180;
    localparam logic [REM_WIDTH-1:0] DEG_270 = 9'd270;
    localparam logic [REM_WIDTH-1:0] DEG_360 = 9'd360;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REDUCE  = 3'd1,
        ST_MAP     = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0]            quad;
        logic [DATA_WIDTH-1:0] idx;
    } lut_req_t;

    // Folds a reduced angle 0..359 onto the LUT's 0..90 reference range.
    function automatic lut_req_t map_quadrant(input logic [REM_WIDTH-1:0] r);
        lut_req_t             m;
        logic [REM_WIDTH-1:0] v;
        if (r <= DEG_90) begin
            m.quad = 2'd0;
            v      = r;
        end else if (r <= DEG_180) begin
            m.quad = 2'd1;
            v      = DEG_180 - r;
        end else if (r <= DEG_270) begin
            m.quad = 2'd2;
            v      = r - DEG_180;
        end else begin
            m.quad = 2'd3;
            v      = DEG_360 - r;
        end
        m.idx = {{(DATA_WIDTH-REM_WIDTH){1'b0}}, v};
        return m;
    endfunction

endpackage

// File: rtl/cosine2x_lut_sequencer_if.sv
// Request/response handshake plus LUT drive bundle for the cosine2x sequencer.
// Latency: n/a (wiring only). Backpressure: valid/ready on req and resp.
interface cosine2x_lut_sequencer_if;

    logic                                                 req_valid;
    logic                                                 req_ready;
    logic [cosine2x_lut_sequencer_pkg::DATA_WIDTH-1:0]    angle_deg;
    logic                                                 resp_valid;
    logic                                                 resp_ready;
    logic [cosine2x_lut_sequencer_pkg::RESULT_WIDTH-1:0]  resp_data;
    logic [1:0]                                           resp_quad;
    logic                                                 lut_en;
    logic [1:0]                                           lut_quadrant;
    logic [cosine2x_lut_sequencer_pkg::DATA_WIDTH-1:0]    lut_index;
    logic [cosine2x_lut_sequencer_pkg::RESULT_WIDTH-1:0]  lut_data;

    modport slave (
        input  req_valid, angle_deg, resp_ready, lut_data,
        output req_ready, resp_valid, resp_data, resp_quad,
               lut_en, lut_quadrant, lut_index
    );

    modport master (
        output req_valid, angle_deg, resp_ready, lut_data,
        input  req_ready, resp_valid, resp_data, resp_quad,
               lut_en, lut_quadrant, lut_index
    );

endinterface

// File: rtl/cosine2x_lut_sequencer_angle_mod360_reducer.sv
// Restoring mod-360 remainder, one dividend bit per cycle, MSB first.
// Latency: DW cycles after start; done is high during the last bit's cycle. No backpressure.
module cosine2x_lut_sequencer_angle_mod360_reducer
    import cosine2x_lut_sequencer_pkg::*;
#(
    parameter int DW = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DW-1:0]        dividend,
    output logic                 done,
    output logic [REM_WIDTH-1:0] remainder
);

    localparam int CW = $clog2(DW);

    logic [DW-1:0]        dvd;
    logic [CW-1:0]        cnt;
    logic                 busy;
    logic [REM_WIDTH-1:0] rem;
    logic [REM_WIDTH:0]   trial;
    logic [REM_WIDTH-1:0] rem_nxt;

    // rem < 360 always, so the shifted trial value never exceeds 719.
    always_comb begin
        trial   = {rem, dvd[cnt]};
        rem_nxt = trial[REM_WIDTH-1:0];
        if (trial >= {1'b0, DEG_360}) begin
            rem_nxt = REM_WIDTH'(trial - {1'b0, DEG_360});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvd  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            rem  <= '0;
        end else if (start) begin
            dvd  <= dividend;
            cnt  <= CW'(DW - 1);
            busy <= 1'b1;
            rem  <= '0;
        end else if (busy) begin
            rem <= rem_nxt;
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done      = busy && (cnt == '0);
    assign remainder = rem;

endmodule

// File: rtl/cosine2x_lut_sequencer.sv
// Reduces an angle mod 360, pulses the cosine2x LUT once and returns the captured double.
// Latency: DATA_WIDTH+3 cycles accept->resp_valid. Backpressure: resp held until resp_ready; req_ready low while busy.
module cosine2x_lut_sequencer
    import cosine2x_lut_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    cosine2x_lut_sequencer_if.slave  bus
);

    state_t                  state, state_nxt;
    logic                    req_ready_r,  req_ready_nxt;
    logic                    resp_valid_r, resp_valid_nxt;
    logic [RESULT_WIDTH-1:0] resp_data_r,  resp_data_nxt;
    logic [1:0]              resp_quad_r,  resp_quad_nxt;
    logic                    lut_en_r,     lut_en_nxt;
    logic [1:0]              lut_quad_r,   lut_quad_nxt;
    logic [DATA_WIDTH-1:0]   lut_index_r,  lut_index_nxt;

    logic                    accept;
    logic                    red_done;
    logic [REM_WIDTH-1:0]    red_rem;
    lut_req_t                mapped;

    assign accept = (state == ST_IDLE) && req_ready_r && bus.req_valid;

    cosine2x_lut_sequencer_angle_mod360_reducer #(
        .DW (DATA_WIDTH)
    ) u_reducer (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (accept),
        .dividend  (bus.angle_deg),
        .done      (red_done),
        .remainder (red_rem)
    );

    assign mapped = map_quadrant(red_rem);

    always_comb begin
        state_nxt      = state;
        resp_valid_nxt = resp_valid_r;
        resp_data_nxt  = resp_data_r;
        resp_quad_nxt  = resp_quad_r;
        lut_en_nxt     = 1'b0;
        lut_quad_nxt   = lut_quad_r;
        lut_index_nxt  = lut_index_r;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_REDUCE;
            end
            ST_REDUCE: begin
                if (red_done) state_nxt = ST_MAP;
            end
            ST_MAP: begin
                state_nxt     = ST_ISSUE;
                lut_en_nxt    = 1'b1;
                lut_quad_nxt  = mapped.quad;
                lut_index_nxt = mapped.idx;
            end
            ST_ISSUE: begin
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // LUT word is valid this cycle only; it floats after the closing edge.
                state_nxt      = ST_RESP;
                resp_data_nxt  = bus.lut_data;
                resp_quad_nxt  = lut_quad_r;
                resp_valid_nxt = 1'b1;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        req_ready_nxt = (state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= '0;
            resp_quad_r  <= '0;
            lut_en_r     <= 1'b0;
            lut_quad_r   <= '0;
            lut_index_r  <= '0;
        end else begin
            state        <= state_nxt;
            req_ready_r  <= req_ready_nxt;
            resp_valid_r <= resp_valid_nxt;
            resp_data_r  <= resp_data_nxt;
            resp_quad_r  <= resp_quad_nxt;
            lut_en_r     <= lut_en_nxt;
            lut_quad_r   <= lut_quad_nxt;
            lut_index_r  <= lut_index_nxt;
        end
    end

    assign bus.req_ready    = req_ready_r;
    assign bus.resp_valid   = resp_valid_r;
    assign bus.resp_data    = resp_data_r;
    assign bus.resp_quad    = resp_quad_r;
    assign bus.lut_en       = lut_en_r;
    assign bus.lut_quadrant = lut_quad_r;
    assign bus.lut_index    = lut_index_r;

endmodule

// File: tb/tb_cosine2x_lut_sequencer.sv
// Scoreboard bench for cosine2x_lut_sequencer with a behavioural LUT model.
module tb_cosine2x_lut_sequencer;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  quad;
    } resp_exp_t;

    typedef struct packed {
        logic [1:0]  quad;
        logic [31:0] idx;
    } lut_exp_t;

    logic clk;
    logic reset_n;

    cosine2x_lut_sequencer_if bus();

    cosine2x_lut_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int accepts = 0;
    int accept_cyc = 0;
    int lut_pulses = 0;
    int pushed = 0;

    resp_exp_t resp_q[$];
    lut_exp_t  lut_q[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout or unexpected event", name);
    endfunction

    // Synthetic LUT contents: sign set for quadrants 1/2, index tagged in the low byte.
    function automatic logic [63:0] lut_word(input logic [1:0] q, input logic [31:0] idx);
        logic [7:0] tag;
        tag = idx[7:0];
        return {(q == 2'd1 || q == 2'd2), 11'h3FF, 44'd0, tag};
    endfunction

    // LUT model: registers on an enabled edge, drives for one cycle, otherwise a junk word.
    logic [63:0] lut_word_r = '0;
    logic        lut_drv    = 1'b0;
    always @(posedge clk) begin
        if (bus.lut_en) begin
            lut_word_r <= lut_word(bus.lut_quadrant, bus.lut_index);
            lut_drv    <= 1'b1;
        end else begin
            lut_drv    <= 1'b0;
        end
    end
    assign bus.lut_data = lut_drv ? lut_word_r : 64'hBAD0_BAD0_BAD0_BAD0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on every LUT pulse and every response handshake.
    initial begin
        bit lut_en_prev = 1'b0;
        bit rv_prev     = 1'b0;
        bit hs_prev     = 1'b0;
        lut_exp_t  le;
        resp_exp_t re;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                lut_en_prev = 1'b0;
                rv_prev     = 1'b0;
                hs_prev     = 1'b0;
            end else begin
                if (hs_prev) check("req_ready_after_hs", {63'd0, bus.req_ready}, 64'd1);
                if (bus.req_valid && bus.req_ready) begin
                    accepts++;
                    accept_cyc = cyc + 1;
                end
                if (bus.lut_en) begin
                    lut_pulses++;
                    check("lut_en_single", {63'd0, lut_en_prev}, 64'd0);
                    if (lut_q.size() == 0) fail_now("lut_en_unexpected");
                    else begin
                        le = lut_q.pop_front();
                        check("lut_quadrant", {62'd0, bus.lut_quadrant}, {62'd0, le.quad});
                        check("lut_index", {32'd0, bus.lut_index}, {32'd0, le.idx});
                    end
                end
                if (bus.resp_valid && !rv_prev)
                    check("latency", 64'(cyc - accept_cyc), 64'd35);
                hs_prev = bus.resp_valid && bus.resp_ready;
                if (hs_prev) begin
                    if (resp_q.size() == 0) fail_now("resp_unexpected");
                    else begin
                        re = resp_q.pop_front();
                        check("resp_data", bus.resp_data, re.data);
                        check("resp_quad", {62'd0, bus.resp_quad}, {62'd0, re.quad});
                    end
                end
                lut_en_prev = bus.lut_en;
                rv_prev     = bus.resp_valid;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [1:0] q, input logic [31:0] idx, input bit push);
        bit ok;
        ok = 1'b0;
        if (push) begin
            resp_q.push_back({lut_word(q, idx), q});
            lut_q.push_back({q, idx});
            pushed++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.angle_deg = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (!ok) fail_now("accept_timeout");
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (resp_q.size() == 0 && lut_q.size() == 0 && bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  {63'd0, bus.req_ready},    64'd0);
        check({tag, "_resp_valid"}, {63'd0, bus.resp_valid},   64'd0);
        check({tag, "_resp_data"},  bus.resp_data,             64'd0);
        check({tag, "_resp_quad"},  {62'd0, bus.resp_quad},    64'd0);
        check({tag, "_lut_en"},     {63'd0, bus.lut_en},       64'd0);
        check({tag, "_lut_quad"},   {62'd0, bus.lut_quadrant}, 64'd0);
        check({tag, "_lut_index"},  {32'd0, bus.lut_index},    64'd0);
    endtask

    // angle, expected quadrant, expected reference index (worked by hand)
    logic [31:0] v_ang [12] = '{32'd0, 32'd135, 32'd300, 32'd90, 32'd180, 32'd270,
                                32'd360, 32'd450, 32'hFFFF_FFFF, 32'd1000, 32'd181, 32'd271};
    logic [1:0]  v_q   [12] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2,
                                2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
    // 0xFFFFFFFF = 360*11930464 + 255 -> q2, 75 ; 1000 -> 280 -> q3, 80
    logic [31:0] v_idx [12] = '{32'd0, 32'd45, 32'd60, 32'd90, 32'd0, 32'd90,
                                32'd0, 32'd90, 32'd75, 32'd80, 32'd1, 32'd89};

    initial begin
        int n_acc;
        bit seen;
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.angle_deg  = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_rst", {63'd0, bus.req_ready}, 64'd1);

        for (int i = 0; i < 12; i++) begin
            send(v_ang[i], v_q[i], v_idx[i], 1'b1);
            wait_drain();
        end

        // Hold the response off for 10 cycles while a new request is offered.
        bus.resp_ready = 1'b0;
        send(32'd135, 2'd1, 32'd45, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("stall_resp_timeout");
        n_acc = accepts;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.angle_deg = 32'd77;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
            check("stall_resp_data",  bus.resp_data, lut_word(2'd1, 32'd45));
            check("stall_req_ready",  {63'd0, bus.req_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("stall_no_accept", 64'(accepts), 64'(n_acc));
        bus.resp_ready = 1'b1;
        wait_drain();

        // Reset in the middle of the reduction.
        send(32'd1234, 2'd0, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_reduce");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (45) @(negedge clk);
        check("rst_reduce_no_resp", {63'd0, bus.resp_valid}, 64'd0);
        check("rst_reduce_ready",   {63'd0, bus.req_ready},  64'd1);

        // Reset while the LUT enable is high.
        send(32'd200, 2'd0, 32'd0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.lut_en) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("issue_timeout");
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("rst_issue");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (45) @(negedge clk);
        check("rst_issue_no_resp", {63'd0, bus.resp_valid}, 64'd0);

        // Recovery after reset.
        send(32'd720, 2'd0, 32'd0, 1'b1);
        wait_drain();

        check("resp_q_empty", 64'(resp_q.size()), 64'd0);
        check("lut_q_empty",  64'(lut_q.size()),  64'd0);
        check("lut_pulses",   64'(lut_pulses),    64'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
